// File: rtl/cache_arb_pkg.sv
// Shared encodings for the two-requester cache port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was
// not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic win
);

  // Winner selection; win=1 means requester 1.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one unhandshaked cache_and_ram port between two req/ack requesters,
// holding each granted transaction on the port for HOLD_CYCLES clocks.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              mode0,
  input  logic              mode1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t              state_r, state_s;
  logic [7:0]          cnt_r, cnt_s;
  logic                win_r, win_s;
  logic                last_r, last_s;
  logic                lmode_r, lmode_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [DATA_W-1:0]   data_s, rdata0_s, rdata1_s;
  logic                mode_s, gnt0_s, gnt1_s, ack0_s, ack1_s;
  logic                pick_valid_s, pick_win_s;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_r),
    .valid (pick_valid_s),
    .win   (pick_win_s)
  );

  // Next-state and next-output logic; everything leaves through registers.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    win_s    = win_r;
    last_s   = last_r;
    lmode_s  = lmode_r;
    addr_s   = mem_address;
    data_s   = mem_data;
    mode_s   = mem_mode;
    gnt0_s   = gnt0;
    gnt1_s   = gnt1;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    rdata0_s = rdata0;
    rdata1_s = rdata1;
    case (state_r)
      ST_IDLE: begin
        mode_s = MODE_READ;
        if (pick_valid_s) begin
          win_s = pick_win_s;
          if (pick_win_s) begin
            addr_s  = addr1;
            data_s  = wdata1;
            lmode_s = mode1;
          end else begin
            addr_s  = addr0;
            data_s  = wdata0;
            lmode_s = mode0;
          end
          mode_s  = lmode_s;
          gnt0_s  = ~pick_win_s;
          gnt1_s  = pick_win_s;
          cnt_s   = HOLD_LAST;
          state_s = ST_BUSY;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_DONE;
          last_s  = win_r;
          mode_s  = MODE_READ;
          ack0_s  = ~win_r;
          ack1_s  = win_r;
          // Only reads capture the cache output; writes leave rdata alone.
          if (lmode_r == MODE_READ) begin
            if (win_r) begin
              rdata1_s = mem_out;
            end else begin
              rdata0_s = mem_out;
            end
          end else begin
            rdata0_s = rdata0;
          end
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        mode_s  = MODE_READ;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also drops any in-flight write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      win_r       <= 1'b0;
      last_r      <= 1'b1;
      lmode_r     <= MODE_READ;
      mem_address <= '0;
      mem_data    <= '0;
      mem_mode    <= MODE_READ;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      win_r       <= win_s;
      last_r      <= last_s;
      lmode_r     <= lmode_s;
      mem_address <= addr_s;
      mem_data    <= data_s;
      mem_mode    <= mode_s;
      gnt0        <= gnt0_s;
      gnt1        <= gnt1_s;
      ack0        <= ack0_s;
      ack1        <= ack1_s;
      rdata0      <= rdata0_s;
      rdata1      <= rdata1_s;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized phase checked against a transaction-level reference model.
module tb_cache_port_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, ack0, ack1, mem_mode;
  logic [31:0] rdata0, rdata1, mem_address, mem_data, mem_out;

  logic [31:0] cache [0:4095] = '{default: 32'd0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .mode0(mode0), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode),
    .mem_out(mem_out)
  );

  always #25 clk = ~clk;

  // Behavioural cache_and_ram: 4096 words, address taken modulo 4096.
  always @(posedge clk) begin
    if (mem_mode) cache[mem_address[11:0]] <= mem_data;
  end
  assign mem_out = cache[mem_address[11:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          r0, r1, m0, m1;
    logic [31:0] a0, a1, d0, d1;
    int          first;
    logic [31:0] rd0, rd1;
    int          wcyc;
  } vec_t;

  vec_t tbl [8];

  task automatic run_round(input vec_t v, output int first, output int wcyc, output bit tmo);
    bit pend0, pend1;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; mode0 = v.m0; mode1 = v.m1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    pend0 = v.r0; pend1 = v.r1; first = -1; wcyc = 0;
    for (int c = 0; c < 200 && (pend0 || pend1); c++) begin
      tick();
      if (mem_mode) wcyc++;
      if (first < 0 && gnt0) first = 0;
      else if (first < 0 && gnt1) first = 1;
      if (ack0) begin pend0 = 1'b0; req0 = 1'b0; end
      if (ack1) begin pend1 = 1'b0; req1 = 1'b0; end
    end
    tmo = pend0 || pend1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  typedef struct { bit active, granted; logic [31:0] addr, wdata; bit mode; } txn_t;

  txn_t        t [2];
  logic [31:0] model_mem [0:15] = '{default: 32'd0};
  logic [31:0] exp_rd [2];

  initial begin
    int first, wcyc, ng, ac, last_m, free_at, grant_cyc, owner, w, w_exp;
    bit tmo, got_ack, overlap, outstanding, rq0, rq1, pg0, pg1, g0r, g1r, exp_grant;
    int seq [6];
    int gc [2];
    logic [31:0] r;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd2001, 32'd2001, 32'd25369366, 32'd0, 0, 32'd0, 32'd25369366, 4};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd14528, 32'd0, 0, 32'd0, 32'd25369366, 4};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'd14528, 32'd25369366, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd2816867292, 32'd0, 32'd526421, 1, 32'd14528, 32'd25369366, 4};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd2816867292, 32'd0, 32'd0, 1, 32'd14528, 32'd526421, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2001, 32'd2816867292, 32'd0, 32'd0, 0, 32'd25369366, 32'd526421, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 32'd14528, 32'd526421, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd5, 32'd5, 32'd77, 32'd0, 1, 32'd14528, 32'd0, 4};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) tick();
    check("rst_gnt", {gnt0, gnt1}, 2'b00);
    check("rst_ack", {ack0, ack1}, 2'b00);
    check("rst_rdata", {rdata0, rdata1}, 64'd0);
    check("rst_mem", {mem_mode, mem_address, mem_data}, 65'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted in the middle of a write aborts it at once.
    @(negedge clk);
    req0 = 1'b1; mode0 = 1'b1; addr0 = 32'd100; wdata0 = 32'd5555;
    tick();
    check("abort_gnt", gnt0, 1'b1);
    check("abort_wr_on", mem_mode, 1'b1);
    tick();
    #10 reset = 1'b1;
    #1;
    check("abort_mode_async", mem_mode, 1'b0);
    check("abort_gnt_async", gnt0, 1'b0);
    check("abort_addr_async", mem_address, 32'd0);
    req0 = 1'b0; mode0 = 1'b0;
    got_ack = 1'b0;
    repeat (3) begin
      tick();
      if (ack0 | ack1) got_ack = 1'b1;
    end
    check("abort_no_ack", got_ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_round(tbl[i], first, wcyc, tmo);
      check($sformatf("vec%0d_timeout", i), tmo, 1'b0);
      check($sformatf("vec%0d_first", i), first, tbl[i].first);
      check($sformatf("vec%0d_rdata0", i), rdata0, tbl[i].rd0);
      check($sformatf("vec%0d_rdata1", i), rdata1, tbl[i].rd1);
      check($sformatf("vec%0d_wr_cycles", i), wcyc, tbl[i].wcyc);
    end

    // Randomized traffic against a transaction-level model.
    exp_rd[0] = tbl[7].rd0; exp_rd[1] = tbl[7].rd1;
    last_m = 0; outstanding = 1'b0; free_at = cyc + 1; grant_cyc = 0; owner = 0;
    pg0 = gnt0; pg1 = gnt1;
    t[0] = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    t[1] = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    for (int k = 0; k < 1500; k++) begin
      rq0 = req0; rq1 = req1;
      tick();
      g0r = gnt0 & ~pg0; g1r = gnt1 & ~pg1;
      exp_grant = !outstanding && (cyc >= free_at) && (rq0 || rq1);
      check("rand_grant_taken", g0r | g1r, exp_grant);
      if (exp_grant && (g0r | g1r)) begin
        w_exp = (rq0 && rq1) ? ((last_m == 0) ? 1 : 0) : (rq1 ? 1 : 0);
        check("rand_winner", g1r, w_exp[0]);
        outstanding = 1'b1; owner = g1r ? 1 : 0; grant_cyc = cyc;
        t[owner].granted = 1'b1;
      end
      check("rand_gnt_excl", gnt0 & gnt1, 1'b0);
      if (ack0 | ack1) begin
        w = ack1 ? 1 : 0;
        check("rand_ack_single", ack0 & ack1, 1'b0);
        check("rand_ack_owner", w, owner);
        check("rand_latency", cyc - grant_cyc, HOLD);
        if (t[w].mode == 1'b0) exp_rd[w] = model_mem[t[w].addr[3:0]];
        else model_mem[t[w].addr[3:0]] = t[w].wdata;
        check("rand_rdata0", rdata0, exp_rd[0]);
        check("rand_rdata1", rdata1, exp_rd[1]);
        last_m = w; outstanding = 1'b0; free_at = cyc + 2;
        t[w].active = 1'b0; t[w].granted = 1'b0;
      end
      pg0 = gnt0; pg1 = gnt1;
      for (int q = 0; q < 2; q++) begin
        if (t[q].active && !t[q].granted && $urandom_range(0, 9) == 0) begin
          t[q].active = 1'b0;
        end else if (!t[q].active && $urandom_range(0, 2) == 0) begin
          r = $urandom();
          t[q].active = 1'b1;
          t[q].addr = (r & 32'hFFFF_F00F) | 32'h0000_0080;
          t[q].wdata = $urandom();
          t[q].mode = ($urandom_range(0, 1) == 1);
        end else begin
          t[q].active = t[q].active;
        end
      end
      req0 = t[0].active; addr0 = t[0].addr; wdata0 = t[0].wdata; mode0 = t[0].mode;
      req1 = t[1].active; addr1 = t[1].addr; wdata1 = t[1].wdata; mode1 = t[1].mode;
    end

    // Fairness: both requests held permanently high.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0; addr0 = 32'd1; addr1 = 32'd2;
    ng = 0; overlap = 1'b0; pg0 = 1'b0; pg1 = 1'b0;
    for (int i = 0; i < 6; i++) seq[i] = -1;
    for (int c = 0; c < 300 && ng < 6; c++) begin
      tick();
      if (gnt0 & ~pg0) begin seq[ng] = 0; ng++; end
      else if (gnt1 & ~pg1) begin seq[ng] = 1; ng++; end
      if (ack0 & ack1) overlap = 1'b1;
      pg0 = gnt0; pg1 = gnt1;
    end
    check("fair_count", ng, 6);
    for (int i = 0; i < 6; i++) check($sformatf("fair_seq%0d", i), seq[i], i % 2);
    check("fair_ack_overlap", overlap, 1'b0);

    // Back-to-back: req0 stays high through its ack.
    do_reset();
    @(negedge clk);
    req1 = 1'b0; req0 = 1'b1; mode0 = 1'b1; addr0 = 32'd300; wdata0 = 32'd9;
    ng = 0; ac = -1; pg0 = 1'b0; gc[0] = 0; gc[1] = 0;
    for (int c = 0; c < 200 && ng < 2; c++) begin
      tick();
      if (gnt0 & ~pg0) begin gc[ng] = cyc; ng++; end
      if (ack0 && ac < 0) ac = cyc;
      pg0 = gnt0;
    end
    check("b2b_grants", ng, 2);
    check("b2b_ack_latency", ac - gc[0], HOLD);
    check("b2b_issue_spacing", gc[1] - gc[0], HOLD + 2);
    req0 = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
